zxn_ram_arbiter: RTL and testbench
==================================

// Module: zxn_ram_arbiter
// PURPOSE
//  Owns the single port of the on-chip 400 KB Next RAM (BRAM).
//  Shares it between the ZXNext core port (priority, fixed 1-cycle read latency) and a loader port (HPS/ROM download).
//  Runs a fill engine that writes FILL_VALUE to every location after reset or on clear_req.
//  Sits between ZXNEXT_Mister's ram_* bus and the BRAM array in emu.
// PARAMETERS
//  ADDR_W      19      address width of all ports (2^19 >= MEM_DEPTH)
//  MEM_DEPTH   409600  number of bytes in the array; fill covers 0..MEM_DEPTH-1
//  FILL_VALUE  8'hFF   byte written by the fill engine
//  STARVE_MAX  1024    consecutive denied loader cycles before ld_starve sets
// PORTS
//  clk_sys     in   1       system clock (28 MHz); sole clock
//  reset_n     in   1       asynchronous active-low reset
//  clear_req   in   1       1-cycle pulse: (re)start full-memory fill
//  clear_busy  out  1       high while fill in progress
//  core_cs     in   1       core access strobe
//  core_we     in   1       core write enable (qualified by core_cs)
//  core_addr   in   ADDR_W  core address
//  core_din    in   8       core write data
//  core_dout   out  8       core read data, valid cycle after the read
//  ld_req      in   1       loader request
//  ld_we       in   1       loader write enable
//  ld_addr     in   ADDR_W  loader address
//  ld_din      in   8       loader write data
//  ld_gnt      out  1       loader access taken this cycle (combinational)
//  ld_rvalid   out  1       ld_dout valid (cycle after granted read)
//  ld_dout     out  8       loader read data
//  ld_starve   out  1       sticky: loader denied STARVE_MAX cycles in a row
//  mem_addr    out  ADDR_W  to BRAM
//  mem_din     out  8       to BRAM
//  mem_we      out  1       to BRAM
//  mem_dout    in   8       from BRAM, registered read (1-cycle latency)
// BEHAVIOUR
//  States: FILL, RUN. Async reset -> FILL (with macro) or RUN (without).
//  Reset values: fill_addr=0; ld_rvalid, ld_starve, mem_we = 0; clear_busy = 1 in FILL, else 0.
//  FILL:
//   - mem_addr=fill_addr, mem_din=FILL_VALUE, mem_we=1; fill_addr++ each cycle.
//   - Core writes are dropped; ld_gnt=0.
//   - At fill_addr==MEM_DEPTH-1 the write occurs, then RUN next cycle; clear_busy falls with the state.
//   - clear_req during FILL restarts at fill_addr=0 the next cycle.
//  RUN:
//   - core_cs=1: core owns the port; mem_we = core_we.
//   - core_cs=0 & ld_req=1: ld_gnt=1 and the loader owns the port.
//   - Neither requesting: mem_we=0, mem_addr holds the last value.
//   - clear_req in RUN -> FILL next cycle with fill_addr=0.
//  Reads:
//   - core_dout = mem_dout every cycle (core samples the cycle after its read).
//   - ld_rvalid registered = granted loader read of the previous cycle; ld_dout = mem_dout.
//  Starvation:
//   - Counter increments while ld_req & core_cs in RUN; clears on ld_gnt or !ld_req.
//   - Reaching STARVE_MAX sets ld_starve, which is cleared only by reset_n or clear_req.
//   - Counter saturates.
//  Simultaneous clear_req and a core/loader access: clear_req wins; that access is still performed in this cycle.
//  fill_addr width ADDR_W; compare against MEM_DEPTH-1, no wrap past it.
// CONFIGURATION
//  ZXN_RAM_CLEAR_EN defined:
//   - Fill engine and FILL state are present; behaviour is as above.
//  ZXN_RAM_CLEAR_EN undefined:
//   - No fill engine; state is always RUN.
//   - clear_busy is tied to 0; clear_req only clears ld_starve.
//   - BRAM contents are undefined at power-up.
// STRUCTURE
//  Package zxn_ram_pkg:
//   - typedef enum logic {ST_FILL, ST_RUN} ram_arb_state_t
//   - typedef enum logic [1:0] {OWN_NONE, OWN_CORE, OWN_LD, OWN_FILL} ram_owner_t
//   - localparam ZXN_RAM_DEPTH=409600, ZXN_RAM_FILL=8'hFF
//  Sub-module zxn_ram_fill:
//   - Owns the fill address counter and done flag; instantiated only under ZXN_RAM_CLEAR_EN.
//  Top-level holds the owner mux, the rvalid register and the starve counter.
// TESTING
//  1. Reset release, MEM_DEPTH=16:
//     - mem_we=1 for exactly 16 cycles, addr 0..15, din FF.
//     - clear_busy falls on cycle 17.
//  2. RUN, core write 0x1234<-0xA5 then read 0x1234:
//     - core_dout=0xA5 on the cycle after the read.
//  3. core_cs=1 and ld_req=1 together:
//     - ld_gnt=0, mem_addr=core_addr.
//     - Next cycle core_cs=0: ld_gnt=1; if that access is a loader read, ld_rvalid=1 one cycle later.
//  4. clear_req mid-fill at fill_addr=9:
//     - The next write is at addr 0; all 16 addresses are rewritten.
//  5. STARVE_MAX=4, core_cs held high with ld_req=1:
//     - ld_starve rises after 4 cycles and stays set after the core goes idle.
//     - clear_req clears it.
//  6. reset_n asserted mid-RUN with a loader read pending:
//     - ld_rvalid=0 immediately (async).
//     - The fill restarts at 0 after release (macro on).

Source files
------------

// File: rtl/zxn_ram_pkg.sv
// Shared types and constants for the Next RAM port arbiter.
// No logic of its own; no latency.
// No flow control; consumers decide ownership and grants.
package zxn_ram_pkg;

  typedef enum logic {ST_FILL, ST_RUN} ram_arb_state_t;

  typedef enum logic [1:0] {OWN_NONE, OWN_CORE, OWN_LD, OWN_FILL} ram_owner_t;

  localparam int         ZXN_RAM_DEPTH  = 409600;
  localparam logic [7:0] ZXN_RAM_FILL   = 8'hFF;
  localparam int         ZXN_RAM_STARVE = 1024;

  // Bits needed to count from 0 up to and including n.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/zxn_ram_fill.sv
// Fill address generator: walks 0..MEM_DEPTH-1 while active, restarts at 0 on request.
// fill_addr is registered; fill_done is a same-cycle compare against the last address.
// No backpressure: one address per cycle while active, nothing can stall it.
module zxn_ram_fill
  import zxn_ram_pkg::*;
#(
  parameter int ADDR_W    = 19,
  parameter int MEM_DEPTH = ZXN_RAM_DEPTH
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              restart,
  input  logic              active,
  output logic [ADDR_W-1:0] fill_addr,
  output logic              fill_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

  assign fill_done = (fill_addr == LAST_ADDR);

  // Advance one location per cycle; park on the last address, restart wins.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      fill_addr <= '0;
    end else if (restart) begin
      fill_addr <= '0;
    end else if (active && !fill_done) begin
      fill_addr <= fill_addr + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/zxn_ram_arbiter.sv
// Single-port Next RAM owner: fill engine > core > loader; optional fill under ZXN_RAM_CLEAR_EN.
// Port mux is combinational; read data returns one cycle after the access (BRAM latency).
// Core never waits; loader is granted only when core_cs is low, ld_starve flags long denial.
module zxn_ram_arbiter
  import zxn_ram_pkg::*;
#(
  parameter int         ADDR_W     = 19,
  parameter int         MEM_DEPTH  = ZXN_RAM_DEPTH,
  parameter logic [7:0] FILL_VALUE = ZXN_RAM_FILL,
  parameter int         STARVE_MAX = ZXN_RAM_STARVE
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              clear_req,
  output logic              clear_busy,
  input  logic              core_cs,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [7:0]        core_din,
  output logic [7:0]        core_dout,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_din,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [7:0]        ld_dout,
  output logic              ld_starve,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  output logic              mem_we,
  input  logic [7:0]        mem_dout
);

  localparam int CNT_W = cnt_width(STARVE_MAX);

  logic              is_fill;
  logic [ADDR_W-1:0] fill_addr;
  ram_owner_t        owner;
  logic [ADDR_W-1:0] last_addr;
  logic              we_sel;
  logic [CNT_W-1:0]  starve_cnt;

`ifdef ZXN_RAM_CLEAR_EN
  ram_arb_state_t state;
  logic           fill_done;

  zxn_ram_fill #(
    .ADDR_W    (ADDR_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_fill (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .restart   (clear_req),
    .active    (is_fill),
    .fill_addr (fill_addr),
    .fill_done (fill_done)
  );

  // FILL after reset or any clear request; RUN once the last location is written.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_FILL;
    end else if (clear_req) begin
      state <= ST_FILL;
    end else if (state == ST_FILL && fill_done) begin
      state <= ST_RUN;
    end
  end

  assign is_fill = (state == ST_FILL);
`else
  // Without the fill engine the port is always in RUN; the fill leg of the mux is dead.
  assign is_fill   = 1'b0;
  assign fill_addr = ADDR_W'(MEM_DEPTH - 1);
`endif

  assign clear_busy = is_fill;

  // Ownership: fill engine first, then the core, then the loader.
  always_comb begin
    owner = OWN_NONE;
    if (is_fill) begin
      owner = OWN_FILL;
    end else if (core_cs) begin
      owner = OWN_CORE;
    end else if (ld_req) begin
      owner = OWN_LD;
    end
  end

  // Drive the BRAM port from the owner; with no owner the address holds its last value.
  always_comb begin
    mem_addr = last_addr;
    mem_din  = core_din;
    we_sel   = 1'b0;
    case (owner)
      OWN_FILL: begin
        mem_addr = fill_addr;
        mem_din  = FILL_VALUE;
        we_sel   = 1'b1;
      end
      OWN_CORE: begin
        mem_addr = core_addr;
        mem_din  = core_din;
        we_sel   = core_we;
      end
      OWN_LD: begin
        mem_addr = ld_addr;
        mem_din  = ld_din;
        we_sel   = ld_we;
      end
      default: begin
        we_sel = 1'b0;
      end
    endcase
  end

  // Keep the BRAM quiet while reset is held, even though the fill state is already selected.
  assign mem_we = we_sel & reset_n;
  assign ld_gnt = (owner == OWN_LD);

  assign core_dout = mem_dout;
  assign ld_dout   = mem_dout;

  // Remember the last driven address so an idle port does not toggle the BRAM address.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      last_addr <= '0;
    end else begin
      last_addr <= mem_addr;
    end
  end

  // Loader read data is valid the cycle after a granted loader read.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ld_rvalid <= 1'b0;
    end else begin
      ld_rvalid <= ld_gnt & ~ld_we;
    end
  end

  // Count consecutive denied loader cycles in RUN; the flag is sticky until clear_req.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
      ld_starve  <= 1'b0;
    end else begin
      if (!is_fill) begin
        if (ld_gnt || !ld_req) begin
          starve_cnt <= '0;
        end else if (starve_cnt != CNT_W'(STARVE_MAX)) begin
          starve_cnt <= starve_cnt + CNT_W'(1);
        end
      end
      if (clear_req) begin
        ld_starve <= 1'b0;
      end else if (!is_fill && ld_req && !ld_gnt && starve_cnt >= CNT_W'(STARVE_MAX - 1)) begin
        ld_starve <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_zxn_ram_arbiter.sv
// Bench for zxn_ram_arbiter with a small memory (16) and short starvation limit (4).
// Directed scenarios plus a randomized run against a shadow-memory reference model.
// Fill-engine scenarios follow ZXN_RAM_CLEAR_EN exactly as the design does.
module tb_zxn_ram_arbiter;

  localparam int         AW    = 19;
  localparam int         DEPTH = 16;
  localparam int         SMAX  = 4;
  localparam logic [7:0] FV    = 8'hFF;

  logic          clk_sys   = 1'b0;
  logic          reset_n   = 1'b0;
  logic          clear_req = 1'b0;
  logic          clear_busy;
  logic          core_cs   = 1'b0;
  logic          core_we   = 1'b0;
  logic [AW-1:0] core_addr = '0;
  logic [7:0]    core_din  = '0;
  logic [7:0]    core_dout;
  logic          ld_req    = 1'b0;
  logic          ld_we     = 1'b0;
  logic [AW-1:0] ld_addr   = '0;
  logic [7:0]    ld_din    = '0;
  logic          ld_gnt;
  logic          ld_rvalid;
  logic [7:0]    ld_dout;
  logic          ld_starve;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din;
  logic          mem_we;
  logic [7:0]    mem_dout  = '0;

  int total = 0;
  int bad   = 0;

  // Reference model state for the randomized run.
  logic [7:0]    shadow [int];
  bit            m_busy;
  int            m_fill;
  int            m_run;
  bit            m_starve;
  logic [AW-1:0] m_last;

  logic [7:0] bram [0:(1<<AW)-1];

  zxn_ram_arbiter #(
    .ADDR_W     (AW),
    .MEM_DEPTH  (DEPTH),
    .FILL_VALUE (FV),
    .STARVE_MAX (SMAX)
  ) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
    .core_cs    (core_cs),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_din   (core_din),
    .core_dout  (core_dout),
    .ld_req     (ld_req),
    .ld_we      (ld_we),
    .ld_addr    (ld_addr),
    .ld_din     (ld_din),
    .ld_gnt     (ld_gnt),
    .ld_rvalid  (ld_rvalid),
    .ld_dout    (ld_dout),
    .ld_starve  (ld_starve),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_we     (mem_we),
    .mem_dout   (mem_dout)
  );

  always #5 clk_sys = ~clk_sys;

  // Behavioural BRAM: read-first, one cycle read latency.
  always @(posedge clk_sys) begin
    if (mem_we) bram[mem_addr] <= mem_din;
    mem_dout <= bram[mem_addr];
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    clear_req = 1'b0; core_cs = 1'b0; core_we = 1'b0; ld_req = 1'b0; ld_we = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    @(posedge clk_sys); #1;
    total++; if (ld_rvalid !== 1'b0) begin bad++; $display("FAIL rst_ld_rvalid got=%b exp=0", ld_rvalid); end
    total++; if (ld_starve !== 1'b0) begin bad++; $display("FAIL rst_ld_starve got=%b exp=0", ld_starve); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
`ifdef ZXN_RAM_CLEAR_EN
    total++; if (clear_busy !== 1'b1) begin bad++; $display("FAIL rst_clear_busy got=%b exp=1", clear_busy); end
    reset_n = 1'b1;
    #1;
    for (int i = 0; i < DEPTH; i++) begin
      total++;
      if ({mem_we, mem_addr, mem_din, clear_busy} !== {1'b1, AW'(i), FV, 1'b1}) begin
        bad++; $display("FAIL fill_cycle%0d got we=%b addr=%0h din=%0h busy=%b exp we=1 addr=%0h din=ff busy=1",
                        i, mem_we, mem_addr, mem_din, clear_busy, i);
      end
      @(posedge clk_sys); #1;
    end
    total++; if ({clear_busy, mem_we} !== 2'b00) begin bad++; $display("FAIL fill_end got busy=%b we=%b exp 0 0", clear_busy, mem_we); end
`else
    total++; if (clear_busy !== 1'b0) begin bad++; $display("FAIL rst_clear_busy got=%b exp=0", clear_busy); end
    reset_n = 1'b1;
    #1;
    total++; if ({clear_busy, mem_we} !== 2'b00) begin bad++; $display("FAIL run_after_rst got busy=%b we=%b exp 0 0", clear_busy, mem_we); end
    @(posedge clk_sys); #1;
`endif
  endtask

  task automatic test_core_rw();
    logic [AW-1:0] a [4];
    logic [7:0]    d [4];
    core_cs = 1'b1; core_we = 1'b1; core_addr = AW'(32'h1234); core_din = 8'hA5;
    #1;
    total++; if ({mem_we, mem_addr, mem_din} !== {1'b1, AW'(32'h1234), 8'hA5}) begin
      bad++; $display("FAIL core_wr_port got we=%b addr=%0h din=%0h exp 1 1234 a5", mem_we, mem_addr, mem_din); end
    @(posedge clk_sys); #1;
    core_we = 1'b0;
    #1;
    total++; if ({mem_we, mem_addr} !== {1'b0, AW'(32'h1234)}) begin
      bad++; $display("FAIL core_rd_port got we=%b addr=%0h exp 0 1234", mem_we, mem_addr); end
    @(posedge clk_sys); #1;
    core_cs = 1'b0;
    total++; if (core_dout !== 8'hA5) begin bad++; $display("FAIL core_rd_data got=%0h exp=a5", core_dout); end
    for (int i = 0; i < 4; i++) begin
      a[i] = AW'(32'h2000 + i * 7); d[i] = 8'($urandom);
      core_cs = 1'b1; core_we = 1'b1; core_addr = a[i]; core_din = d[i];
      @(posedge clk_sys); #1;
    end
    core_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      core_addr = a[i];
      @(posedge clk_sys); #1;
      total++; if (core_dout !== d[i]) begin bad++; $display("FAIL core_b2b_rd%0d got=%0h exp=%0h", i, core_dout, d[i]); end
    end
    idle_inputs();
  endtask

  task automatic test_priority();
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = AW'(32'h3000); ld_din = 8'h5C;
    #1;
    total++; if ({ld_gnt, mem_we, mem_addr} !== {2'b11, AW'(32'h3000)}) begin
      bad++; $display("FAIL ld_wr got gnt=%b we=%b addr=%0h exp 1 1 3000", ld_gnt, mem_we, mem_addr); end
    @(posedge clk_sys); #1;
    core_cs = 1'b1; core_we = 1'b0; core_addr = AW'(32'h1234);
    ld_we = 1'b0;
    #1;
    total++; if ({ld_gnt, mem_addr} !== {1'b0, AW'(32'h1234)}) begin
      bad++; $display("FAIL prio_core got gnt=%b addr=%0h exp 0 1234", ld_gnt, mem_addr); end
    @(posedge clk_sys); #1;
    total++; if ({ld_rvalid, core_dout} !== {1'b0, 8'hA5}) begin
      bad++; $display("FAIL prio_core_rd got rvalid=%b dout=%0h exp 0 a5", ld_rvalid, core_dout); end
    core_cs = 1'b0;
    #1;
    total++; if ({ld_gnt, mem_we, mem_addr} !== {2'b10, AW'(32'h3000)}) begin
      bad++; $display("FAIL prio_ld got gnt=%b we=%b addr=%0h exp 1 0 3000", ld_gnt, mem_we, mem_addr); end
    @(posedge clk_sys); #1;
    ld_req = 1'b0;
    total++; if ({ld_rvalid, ld_dout} !== {1'b1, 8'h5C}) begin
      bad++; $display("FAIL ld_rd got rvalid=%b dout=%0h exp 1 5c", ld_rvalid, ld_dout); end
    #1;
    total++; if ({ld_gnt, mem_we, mem_addr} !== {2'b00, AW'(32'h3000)}) begin
      bad++; $display("FAIL idle_hold got gnt=%b we=%b addr=%0h exp 0 0 3000", ld_gnt, mem_we, mem_addr); end
    @(posedge clk_sys); #1;
    total++; if (ld_rvalid !== 1'b0) begin bad++; $display("FAIL ld_rvalid_drop got=%b exp=0", ld_rvalid); end
  endtask

  task automatic test_clear();
`ifdef ZXN_RAM_CLEAR_EN
    clear_req = 1'b1;
    @(posedge clk_sys); #1;
    clear_req = 1'b0;
    total++; if (clear_busy !== 1'b1) begin bad++; $display("FAIL clr_busy got=%b exp=1", clear_busy); end
    for (int i = 0; i < 10; i++) begin
      if (i == 9) begin
        clear_req = 1'b1; core_cs = 1'b1; core_we = 1'b1; core_addr = AW'(32'h55); ld_req = 1'b1;
      end
      #1;
      total++; if ({mem_we, mem_addr, ld_gnt} !== {1'b1, AW'(i), 1'b0}) begin
        bad++; $display("FAIL clr_pre%0d got we=%b addr=%0h gnt=%b exp 1 %0h 0", i, mem_we, mem_addr, ld_gnt, i); end
      @(posedge clk_sys); #1;
      idle_inputs();
    end
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      total++; if ({mem_we, mem_addr, mem_din} !== {1'b1, AW'(i), FV}) begin
        bad++; $display("FAIL clr_refill%0d got we=%b addr=%0h din=%0h exp 1 %0h ff", i, mem_we, mem_addr, mem_din, i); end
      @(posedge clk_sys); #1;
    end
    total++; if (clear_busy !== 1'b0) begin bad++; $display("FAIL clr_done got=%b exp=0", clear_busy); end
`else
    clear_req = 1'b1;
    #1;
    total++; if (clear_busy !== 1'b0) begin bad++; $display("FAIL clr_busy got=%b exp=0", clear_busy); end
    @(posedge clk_sys); #1;
    clear_req = 1'b0;
    #1;
    total++; if ({clear_busy, mem_we} !== 2'b00) begin bad++; $display("FAIL clr_no_fill got busy=%b we=%b exp 0 0", clear_busy, mem_we); end
    @(posedge clk_sys); #1;
`endif
  endtask

  task automatic test_starve();
    core_cs = 1'b1; core_we = 1'b0; core_addr = '0; ld_req = 1'b1; ld_we = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk_sys); #1;
      total++; if (ld_starve !== (i >= SMAX)) begin
        bad++; $display("FAIL starve_cyc%0d got=%b exp=%b", i, ld_starve, (i >= SMAX)); end
    end
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_sys); #1;
      total++; if (ld_starve !== 1'b1) begin bad++; $display("FAIL starve_sticky%0d got=%b exp=1", i, ld_starve); end
    end
    clear_req = 1'b1;
    @(posedge clk_sys); #1;
    clear_req = 1'b0;
    total++; if (ld_starve !== 1'b0) begin bad++; $display("FAIL starve_clear got=%b exp=0", ld_starve); end
    for (int k = 0; k < 4 * DEPTH && clear_busy; k++) begin
      @(posedge clk_sys); #1;
    end
    total++; if (clear_busy !== 1'b0) begin bad++; $display("FAIL starve_fill_timeout got=%b exp=0", clear_busy); end
  endtask

  task automatic test_async_reset();
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = AW'(32'h3000);
    @(posedge clk_sys); #1;
    ld_req = 1'b0;
    total++; if (ld_rvalid !== 1'b1) begin bad++; $display("FAIL arst_pending got=%b exp=1", ld_rvalid); end
    #2;
    reset_n = 1'b0;
    #1;
    total++; if ({ld_rvalid, mem_we} !== 2'b00) begin bad++; $display("FAIL arst_async got rvalid=%b we=%b exp 0 0", ld_rvalid, mem_we); end
    @(posedge clk_sys); #1;
    reset_n = 1'b1;
    #1;
`ifdef ZXN_RAM_CLEAR_EN
    total++; if ({mem_we, mem_addr, clear_busy} !== {1'b1, AW'(0), 1'b1}) begin
      bad++; $display("FAIL arst_refill got we=%b addr=%0h busy=%b exp 1 0 1", mem_we, mem_addr, clear_busy); end
    for (int k = 0; k < 4 * DEPTH && clear_busy; k++) begin
      @(posedge clk_sys); #1;
    end
`else
    total++; if ({mem_we, clear_busy} !== 2'b00) begin bad++; $display("FAIL arst_run got we=%b busy=%b exp 0 0", mem_we, clear_busy); end
    @(posedge clk_sys); #1;
`endif
    total++; if (clear_busy !== 1'b0) begin bad++; $display("FAIL arst_busy_end got=%b exp=0", clear_busy); end
  endtask

  task automatic test_random();
    logic [AW-1:0] ea;
    logic          ewe, egnt, p_ld, k_core, k_ld;
    logic [7:0]    x_core, x_ld;
    bit            run, denied;
    shadow.delete();
    core_cs = 1'b1; core_we = 1'b1; core_addr = AW'(32'h100); core_din = 8'h3C;
    ld_req = 1'b0; clear_req = 1'b0;
    @(posedge clk_sys); #1;
    shadow[32'h100] = 8'h3C;
    m_last = AW'(32'h100); m_busy = 1'b0; m_fill = 0; m_run = 0; m_starve = 1'b0;
    for (int n = 0; n < 400; n++) begin
      core_cs   = ($urandom_range(0, 9) < 4);
      core_we   = 1'($urandom_range(0, 1));
      core_addr = AW'(32'h100 + $urandom_range(0, 31));
      core_din  = 8'($urandom);
      ld_req    = 1'($urandom_range(0, 1));
      ld_we     = 1'($urandom_range(0, 1));
      ld_addr   = AW'(32'h100 + $urandom_range(0, 31));
      ld_din    = 8'($urandom);
      clear_req = ($urandom_range(0, 49) == 0);
      run = !m_busy;
      if (!run)         begin ea = AW'(m_fill); ewe = 1'b1;    egnt = 1'b0; end
      else if (core_cs) begin ea = core_addr;   ewe = core_we; egnt = 1'b0; end
      else if (ld_req)  begin ea = ld_addr;     ewe = ld_we;   egnt = 1'b1; end
      else              begin ea = m_last;      ewe = 1'b0;    egnt = 1'b0; end
      #1;
      total++; if ({mem_we, mem_addr, ld_gnt, clear_busy} !== {ewe, ea, egnt, !run}) begin
        bad++; $display("FAIL rnd%0d_port got we=%b addr=%0h gnt=%b busy=%b exp %b %0h %b %b",
                        n, mem_we, mem_addr, ld_gnt, clear_busy, ewe, ea, egnt, !run); end
      k_core = run && core_cs && !core_we && shadow.exists(int'(core_addr));
      if (k_core) x_core = shadow[int'(core_addr)];
      p_ld = egnt && !ld_we;
      k_ld = p_ld && shadow.exists(int'(ld_addr));
      if (k_ld) x_ld = shadow[int'(ld_addr)];
      if (run && core_cs && core_we) shadow[int'(core_addr)] = core_din;
      else if (egnt && ld_we)        shadow[int'(ld_addr)]   = ld_din;
      m_last = ea;
      denied = run && ld_req && core_cs;
      if (run) m_run = denied ? m_run + 1 : 0;
      if (clear_req) m_starve = 1'b0;
      else if (denied && m_run >= SMAX) m_starve = 1'b1;
`ifdef ZXN_RAM_CLEAR_EN
      if (clear_req) begin m_busy = 1'b1; m_fill = 0; end
      else if (m_busy) begin
        if (m_fill == DEPTH - 1) m_busy = 1'b0;
        else m_fill++;
      end
`endif
      @(posedge clk_sys); #1;
      total++; if ({ld_rvalid, ld_starve} !== {p_ld, m_starve}) begin
        bad++; $display("FAIL rnd%0d_flags got rvalid=%b starve=%b exp %b %b", n, ld_rvalid, ld_starve, p_ld, m_starve); end
      if (k_ld) begin
        total++; if (ld_dout !== x_ld) begin bad++; $display("FAIL rnd%0d_ld_dout got=%0h exp=%0h", n, ld_dout, x_ld); end
      end
      if (k_core) begin
        total++; if (core_dout !== x_core) begin bad++; $display("FAIL rnd%0d_core_dout got=%0h exp=%0h", n, core_dout, x_core); end
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_core_rw();
    test_priority();
    test_clear();
    test_starve();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
